fault_pro_mc: RTL and testbench
===============================

# fault_pro_mc

Multi-channel, parametrised fault checker for sampled data words. Per sample it applies one of four integrity checks: even parity, odd parity, stuck-value or upper-limit. It keeps a per-channel error counter and a three-state health machine with sticky fault flags. It sits beside the co-processor datapath, taking the same input-byte stream tagged with a channel number, and drives status and alarm pins at the chip top.

## Interface
- WIDTH, 8: data word width (>=2)
- CHANNELS, 4: number of independent channels (>=1)
- CNT_W, 4: error counter width; counters saturate at 2^CNT_W-1
- THRESH, 3: error count at which a channel enters FAULT (1..2^CNT_W-1)
- STUCK_LIM, 4: consecutive repeats of the previous value that flag a stuck error (>=1)
- LIMIT, 8'hC0: range-check ceiling; values strictly greater are errors (WIDTH bits)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- din  in  WIDTH  sample word
- din_valid  in  1  sample qualifier
- ch_sel  in  max(1,$clog2(CHANNELS))  channel of this sample
- mode  in  2  check for this sample: 00 even parity, 01 odd parity, 10 stuck, 11 range
- clear  in  1  global clear of counters, flags, history (not a reset)
- stat_ch  in  max(1,$clog2(CHANNELS))  channel selected for status readback
- res_valid  out  1  result strobe, one cycle per accepted sample
- res_err  out  1  accepted sample failed its check
- res_ch  out  max(1,$clog2(CHANNELS))  channel of the result
- fault_flags  out  CHANNELS  sticky per-channel FAULT indicator
- alarm  out  1  OR of fault_flags (combinational from registered flags)
- stat_count  out  CNT_W  error count of stat_ch
- stat_state  out  2  state of stat_ch: 00 OK, 01 SUSPECT, 10 FAULT

## Operation
- A sample is accepted when din_valid=1, clear=0, reset=0 and ch_sel<CHANNELS. Other samples are dropped with no result and no state change.
- Parity checks use the XOR of all WIDTH bits. Mode 00 fails when the XOR is 1. Mode 01 fails when the XOR is 0.
- Stuck check:
  - Each channel holds last value, a valid bit and a saturating run counter.
  - If the history is valid and din equals the last value, run increments. Otherwise run is 0.
  - Mode 10 fails when run after update >= STUCK_LIM.
  - History updates on every accepted sample in any mode. The first sample after reset or clear has an invalid history, so run=0.
- Range check: mode 11 fails when din > LIMIT (unsigned).
- Error counter and health FSM, per channel:
  - On an error, count = min(count+1, 2^CNT_W-1).
  - On a pass in SUSPECT, count = count-1.
  - On a pass in OK or FAULT, count is unchanged.
  - State is derived at each update: new count >= THRESH, or already in FAULT, gives FAULT. Otherwise new count > 0 gives SUSPECT. Otherwise OK.
  - FAULT is left only via clear or reset.
- fault_flags[i] is 1 exactly when channel i is in FAULT.
- clear: same cycle, all counts go to 0, states to OK, flags to 0 and histories to invalid. Any coincident sample is dropped, with no res_valid.
- Simultaneous events on different channels cannot occur, since there is one sample per cycle.

## Timing
- Reset values: res_valid=0, res_err=0, res_ch=0, fault_flags=0, alarm=0, stat_count=0, stat_state=00.
- Latency is 1 cycle. For a sample accepted at edge N:
  - res_valid, res_err and res_ch are high or valid for the cycle after edge N.
  - Counter, state and flags hold their new values after edge N.
- res_valid is a one-cycle pulse per accepted sample. Back-to-back samples give back-to-back pulses.
- alarm follows fault_flags with zero added latency.
- stat_count and stat_state are registered at each edge from stat_ch's state as it was before that edge's update. A sample update is therefore visible on the stat outputs one cycle after it appears in fault_flags.
- Reset mid-operation takes effect at the next edge regardless of din_valid or clear. There is no pending result, and the result strobe is squashed.

## Test plan
- Default parameters, ch0 mode 00, din=8'h07 for three consecutive cycles:
  - res_err=1 each cycle.
  - stat_state goes 01,01,10 and stat_count goes 1,2,3.
  - fault_flags=4'b0001 and alarm=1 after the third sample.
- ch1 mode 00: 8'h07 then 8'h03 gives res_err 1 then 0; count 1 then 0; state SUSPECT then OK; fault_flags[1]=0 throughout.
- ch2 mode 10: 8'h55 six times gives res_err 0,0,0,0,1,1. Then 8'hAA gives res_err=0 and run resets to 0.
- ch3 mode 11: 8'hC1 gives res_err=1; 8'hC0 gives res_err=0. ch_sel out of range (CHANNELS=3 build, ch_sel=3) gives no res_valid.
- Saturation: 20 errors on ch0 give stat_count=4'hF, held. 5 subsequent passes leave 4'hF and FAULT.
- clear asserted in the same cycle as an erroring ch0 sample while ch0 is in FAULT:
  - next cycle res_valid=0, fault_flags=0, alarm=0;
  - stat_count=0 one cycle later.
  - Reset asserted mid-stream gives the same all-zero outputs at the next edge.

Source files
------------

// File: rtl/fault_pro_mc.sv
// Multi-channel sample integrity checker: parity / stuck / range checks feeding
// per-channel saturating error counters and a sticky OK/SUSPECT/FAULT health machine.
module fault_pro_mc #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned THRESH    = 3,
   parameter int unsigned STUCK_LIM = 4,
   parameter logic [WIDTH-1:0] LIMIT = WIDTH'(8'hC0),
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  din,
   input  logic              din_valid,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic [1:0]        mode,
   input  logic              clear,
   input  logic [CH_W-1:0]   stat_ch,
   output logic              res_valid,
   output logic              res_err,
   output logic [CH_W-1:0]   res_ch,
   output logic [CHANNELS-1:0] fault_flags,
   output logic              alarm,
   output logic [CNT_W-1:0]  stat_count,
   output logic [1:0]        stat_state
);

   localparam int unsigned RUN_W = $clog2(STUCK_LIM + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LIM);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULT   = 2'b10
   } health_e;

   health_e             state_q [CHANNELS];
   health_e             state_d [CHANNELS];
   logic [CNT_W-1:0]    count_q [CHANNELS];
   logic [CNT_W-1:0]    count_d [CHANNELS];
   logic [WIDTH-1:0]    last_q  [CHANNELS];
   logic [WIDTH-1:0]    last_d  [CHANNELS];
   logic                hist_q  [CHANNELS];
   logic                hist_d  [CHANNELS];
   logic [RUN_W-1:0]    run_q   [CHANNELS];
   logic [RUN_W-1:0]    run_d   [CHANNELS];
   logic [CHANNELS-1:0] flags_d;

   health_e          sel_state_c;
   logic [CNT_W-1:0] sel_count_c;
   logic [WIDTH-1:0] sel_last_c;
   logic             sel_hist_c;
   logic [RUN_W-1:0] sel_run_c;
   logic [CNT_W-1:0] stat_count_c;
   logic [1:0]       stat_state_c;
   logic             accept_c;
   logic             err_c;
   logic [RUN_W-1:0] run_c;
   logic [CNT_W-1:0] cnt_c;
   health_e          state_c;

   // Pick out the sampled channel and the status-readback channel.
   always_comb begin
      sel_state_c  = ST_OK;
      sel_count_c  = '0;
      sel_last_c   = '0;
      sel_hist_c   = 1'b0;
      sel_run_c    = '0;
      stat_count_c = '0;
      stat_state_c = 2'b00;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (32'(ch_sel) == i) begin
            sel_state_c = state_q[i];
            sel_count_c = count_q[i];
            sel_last_c  = last_q[i];
            sel_hist_c  = hist_q[i];
            sel_run_c   = run_q[i];
         end
         if (32'(stat_ch) == i) begin
            stat_count_c = count_q[i];
            stat_state_c = state_q[i];
         end
      end
   end

   // Integrity check for the current sample.
   always_comb begin
      accept_c = din_valid && !clear && (32'(ch_sel) < CHANNELS);
      run_c    = '0;
      if (sel_hist_c && (din == sel_last_c))
         run_c = (sel_run_c == RUN_MAX) ? RUN_MAX : sel_run_c + RUN_W'(1);
      err_c = 1'b0;
      unique case (mode)
         2'b00:   err_c = ^din;
         2'b01:   err_c = ~^din;
         2'b10:   err_c = (32'(run_c) >= STUCK_LIM);
         2'b11:   err_c = (din > LIMIT);
         default: err_c = 1'b0;
      endcase
   end

   // Counter and health next-state; clear wins over any coincident sample.
   always_comb begin
      cnt_c = sel_count_c;
      if (err_c)
         cnt_c = (sel_count_c == CNT_MAX) ? CNT_MAX : sel_count_c + CNT_W'(1);
      else if (sel_state_c == ST_SUSPECT)
         cnt_c = sel_count_c - CNT_W'(1);

      if ((sel_state_c == ST_FAULT) || (32'(cnt_c) >= THRESH))
         state_c = ST_FAULT;
      else if (cnt_c != '0)
         state_c = ST_SUSPECT;
      else
         state_c = ST_OK;

      for (int unsigned i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         last_d[i]  = last_q[i];
         hist_d[i]  = hist_q[i];
         run_d[i]   = run_q[i];
         if (clear) begin
            state_d[i] = ST_OK;
            count_d[i] = '0;
            hist_d[i]  = 1'b0;
            run_d[i]   = '0;
         end else if (accept_c && (32'(ch_sel) == i)) begin
            state_d[i] = state_c;
            count_d[i] = cnt_c;
            last_d[i]  = din;
            hist_d[i]  = 1'b1;
            run_d[i]   = run_c;
         end
         flags_d[i] = (state_d[i] == ST_FAULT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_OK;
            count_q[i] <= '0;
            last_q[i]  <= '0;
            hist_q[i]  <= 1'b0;
            run_q[i]   <= '0;
         end
         res_valid   <= 1'b0;
         res_err     <= 1'b0;
         res_ch      <= '0;
         fault_flags <= '0;
         stat_count  <= '0;
         stat_state  <= 2'b00;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
            last_q[i]  <= last_d[i];
            hist_q[i]  <= hist_d[i];
            run_q[i]   <= run_d[i];
         end
         res_valid   <= accept_c;
         res_err     <= accept_c & err_c;
         res_ch      <= accept_c ? ch_sel : res_ch;
         fault_flags <= flags_d;
         stat_count  <= stat_count_c;
         stat_state  <= stat_state_c;
      end
   end

   assign alarm = |fault_flags;

endmodule

// File: tb/tb_fault_pro_mc.sv
// Randomised + directed bench for fault_pro_mc against a behavioural channel model;
// a second 3-channel instance checks that out-of-range channels are dropped.
module tb_fault_pro_mc;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic [1:0] ch_sel = '0;
   logic [1:0] mode = '0;
   logic       clear = 1'b0;
   logic [1:0] stat_ch = '0;

   logic       res_valid, res_err, alarm;
   logic [1:0] res_ch, stat_state;
   logic [3:0] fault_flags, stat_count;

   logic       r3_valid, r3_err, r3_alarm;
   logic [1:0] r3_ch, r3_state;
   logic [2:0] r3_flags;
   logic [3:0] r3_count;

   int checks = 0;
   int failures = 0;

   fault_pro_mc dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .ch_sel(ch_sel),
      .mode(mode), .clear(clear), .stat_ch(stat_ch), .res_valid(res_valid),
      .res_err(res_err), .res_ch(res_ch), .fault_flags(fault_flags), .alarm(alarm),
      .stat_count(stat_count), .stat_state(stat_state)
   );

   fault_pro_mc #(.CHANNELS(3)) dut3 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .ch_sel(ch_sel),
      .mode(mode), .clear(clear), .stat_ch(stat_ch), .res_valid(r3_valid),
      .res_err(r3_err), .res_ch(r3_ch), .fault_flags(r3_flags), .alarm(r3_alarm),
      .stat_count(r3_count), .stat_state(r3_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: count, sticky fault bit, last value, history-valid, run length.
   int         m_cnt   [4];
   bit         m_fault [4];
   logic [7:0] m_last  [4];
   bit         m_hv    [4];
   int         m_run   [4];

   function automatic int state_of(input int i);
      if (m_fault[i]) return 2;
      return (m_cnt[i] > 0) ? 1 : 0;
   endfunction

   always @(posedge clk) begin : model_compare
      bit         e_valid, e_err, e3_valid, err;
      int         e_ch, e_count, e_state, c;
      logic [3:0] ef;
      e_count  = m_cnt[int'(stat_ch)];
      e_state  = state_of(int'(stat_ch));
      e3_valid = !reset && din_valid && !clear && (ch_sel < 2'd3);
      e_valid  = 1'b0;
      e_err    = 1'b0;
      e_ch     = 0;
      if (reset || clear) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_fault[i] = 1'b0; m_hv[i] = 1'b0; m_run[i] = 0;
         end
         if (reset) begin
            e_count = 0;
            e_state = 0;
            e3_valid = 1'b0;
         end
      end else if (din_valid) begin
         c = int'(ch_sel);
         m_run[c]  = (m_hv[c] && din == m_last[c]) ? m_run[c] + 1 : 0;
         m_last[c] = din;
         m_hv[c]   = 1'b1;
         case (mode)
            2'd0: err = ^din;
            2'd1: err = !(^din);
            2'd2: err = (m_run[c] >= 4);
            default: err = (din > 8'hC0);
         endcase
         if (err) m_cnt[c] = (m_cnt[c] < 15) ? m_cnt[c] + 1 : 15;
         else if (!m_fault[c] && m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
         if (m_cnt[c] >= 3) m_fault[c] = 1'b1;
         e_valid = 1'b1;
         e_err   = err;
         e_ch    = c;
      end
      for (int i = 0; i < 4; i++) ef[i] = m_fault[i];
      #1;
      chk("res_valid", 32'(res_valid), 32'(e_valid));
      if (e_valid) begin
         chk("res_err", 32'(res_err), 32'(e_err));
         chk("res_ch", 32'(res_ch), 32'(e_ch));
      end
      chk("fault_flags", 32'(fault_flags), 32'(ef));
      chk("alarm", 32'(alarm), 32'(ef != 4'b0));
      chk("stat_count", 32'(stat_count), 32'(e_count));
      chk("stat_state", 32'(stat_state), 32'(e_state));
      chk("res_valid_3ch", 32'(r3_valid), 32'(e3_valid));
   end

   // Drive one cycle of inputs at a falling edge, return at the next falling edge.
   task automatic cyc(input logic v, input logic [1:0] ch, input logic [1:0] md,
                      input logic [7:0] d, input logic clr);
      din_valid = v; ch_sel = ch; mode = md; din = d; clear = clr;
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] stuck_exp;
      stuck_exp = 6'b110000;
      repeat (3) @(negedge clk);
      chk("lit_reset_valid", 32'(res_valid), 32'd0);
      chk("lit_reset_flags", 32'(fault_flags), 32'd0);
      chk("lit_reset_count", 32'(stat_count), 32'd0);
      reset = 1'b0;

      // ch0 even parity with odd-weight word: three errors into FAULT
      stat_ch = 2'd0;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 2'd0, 2'd0, 8'h07, 1'b0);
         chk("lit_t1_err", 32'(res_err), 32'd1);
      end
      chk("lit_t1_flags", 32'(fault_flags), 32'h1);
      chk("lit_t1_alarm", 32'(alarm), 32'd1);
      chk("lit_t1_cnt_lag", 32'(stat_count), 32'd2);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      chk("lit_t1_count", 32'(stat_count), 32'd3);
      chk("lit_t1_state", 32'(stat_state), 32'd2);

      // ch1 error then pass returns to OK
      stat_ch = 2'd1;
      cyc(1'b1, 2'd1, 2'd0, 8'h07, 1'b0);
      chk("lit_t2_err1", 32'(res_err), 32'd1);
      cyc(1'b1, 2'd1, 2'd0, 8'h03, 1'b0);
      chk("lit_t2_err2", 32'(res_err), 32'd0);
      chk("lit_t2_cnt_lag", 32'(stat_count), 32'd1);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      chk("lit_t2_count", 32'(stat_count), 32'd0);
      chk("lit_t2_flag1", 32'(fault_flags[1]), 32'd0);

      // ch2 stuck detection
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 2'd2, 2'd2, 8'h55, 1'b0);
         chk("lit_t3_stuck", 32'(res_err), 32'(stuck_exp[k]));
      end
      cyc(1'b1, 2'd2, 2'd2, 8'hAA, 1'b0);
      chk("lit_t3_change", 32'(res_err), 32'd0);
      cyc(1'b1, 2'd2, 2'd2, 8'h55, 1'b0);
      chk("lit_t3_rerun", 32'(res_err), 32'd0);

      // ch3 range, and ch3 dropped by the 3-channel build
      cyc(1'b1, 2'd3, 2'd3, 8'hC1, 1'b0);
      chk("lit_t4_over", 32'(res_err), 32'd1);
      chk("lit_t4_drop3", 32'(r3_valid), 32'd0);
      cyc(1'b1, 2'd3, 2'd3, 8'hC0, 1'b0);
      chk("lit_t4_edge", 32'(res_err), 32'd0);

      // saturation on ch0 (already FAULT)
      stat_ch = 2'd0;
      repeat (20) cyc(1'b1, 2'd0, 2'd0, 8'h07, 1'b0);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      chk("lit_sat_count", 32'(stat_count), 32'hF);
      repeat (5) cyc(1'b1, 2'd0, 2'd0, 8'h03, 1'b0);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      chk("lit_sat_hold", 32'(stat_count), 32'hF);
      chk("lit_sat_state", 32'(stat_state), 32'd2);

      // clear coincident with an erroring sample
      cyc(1'b1, 2'd0, 2'd0, 8'h07, 1'b1);
      chk("lit_clr_valid", 32'(res_valid), 32'd0);
      chk("lit_clr_flags", 32'(fault_flags), 32'd0);
      chk("lit_clr_alarm", 32'(alarm), 32'd0);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      chk("lit_clr_count", 32'(stat_count), 32'd0);

      // reset mid-stream
      repeat (3) cyc(1'b1, 2'd0, 2'd0, 8'h07, 1'b0);
      reset = 1'b1;
      cyc(1'b1, 2'd0, 2'd0, 8'h07, 1'b0);
      chk("lit_rst_valid", 32'(res_valid), 32'd0);
      chk("lit_rst_flags", 32'(fault_flags), 32'd0);
      chk("lit_rst_count", 32'(stat_count), 32'd0);
      chk("lit_rst_state", 32'(stat_state), 32'd0);
      reset = 1'b0;

      // randomised traffic, biased toward repeats and values near the limit
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] d;
         case ($urandom_range(0, 2))
            0: d = 8'($urandom);
            1: d = din;
            default: d = 8'hBF + 8'($urandom_range(0, 3));
         endcase
         reset   = ($urandom_range(0, 199) == 0);
         stat_ch = 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             d, ($urandom_range(0, 49) == 0));
      end
      reset = 1'b0;
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
